// File: rtl/text_painter_pipe_if.sv
// text_painter_pipe_if: memory-side bus of the text painter (text RAM read port + glyph ROM read port).
// master = painter, slave = memories.
interface text_painter_pipe_if #(
    parameter int FONT_W = 8,
    parameter int FONT_H = 16,
    parameter int COLS   = 80,
    parameter int ROWS   = 30
);
    localparam int TA_W = $clog2(COLS*ROWS);
    localparam int GA_W = $clog2(128*FONT_H);

    // No valid/ready: the master presents an address every cycle and the slave
    // returns the addressed word exactly one clock later, with no stalls.
    logic [TA_W-1:0]   text_addr;
    logic [31:0]       text_data;
    logic [GA_W-1:0]   glyph_addr;
    logic [FONT_W-1:0] glyph_data;

    modport master (output text_addr, output glyph_addr, input text_data, input glyph_data);
    modport slave  (input text_addr, input glyph_addr, output text_data, output glyph_data);
endinterface

// File: rtl/text_painter_pipe.sv
// text_painter_pipe: 4-stage VGA text renderer (coordinate -> cell -> text RAM -> glyph ROM -> pixel).
// Optional blinking underline cursor is built when TEXT_PAINTER_CURSOR_EN is defined.
module text_painter_pipe #(
    parameter int FONT_W       = 8,
    parameter int FONT_H       = 16,
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int CHAR_W       = 7,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [9:0]                   i_horz_coord,
    input  logic [9:0]                   i_vert_coord,
    input  logic                         i_active,
    input  logic                         i_frame_start,
    input  logic [23:0]                  i_bg_color,
    input  logic [$clog2(COLS*ROWS)-1:0] i_cursor_pos,
    output logic                         o_pixel,
    output logic [23:0]                  o_colors,
    output logic                         o_out_valid,
    text_painter_pipe_if.master          bus
);

    localparam int TA_W   = $clog2(COLS*ROWS);
    localparam int GA_W   = $clog2(128*FONT_H);
    localparam int FW_LOG = $clog2(FONT_W);
    localparam int FH_LOG = $clog2(FONT_H);

    logic [11:0]       w_cx;
    logic [11:0]       w_cy;
    logic [11:0]       w_cell;
    logic [FH_LOG-1:0] w_row;
    logic [FW_LOG-1:0] w_col;
    logic              w_in_range;
    logic              w_s1_valid;
    logic              w_cur_hit;

    assign w_cx   = 12'(i_horz_coord >> FW_LOG);
    assign w_cy   = 12'(i_vert_coord >> FH_LOG);
    assign w_cell = w_cy * 12'(COLS) + w_cx;
    assign w_row  = i_vert_coord[FH_LOG-1:0];
    assign w_col  = i_horz_coord[FW_LOG-1:0];

    // Column and row are bounded separately: x past the last column would
    // otherwise alias onto the start of the next text row.
    assign w_in_range = (w_cx < 12'(COLS)) && (w_cy < 12'(ROWS)) &&
                        (w_cell < 12'(COLS*ROWS));
    assign w_s1_valid = i_active && w_in_range;

`ifdef TEXT_PAINTER_CURSOR_EN
    localparam int BC_W = $clog2(BLINK_FRAMES) + 1;

    logic [BC_W-1:0] r_blink_cnt;
    logic            r_blink_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (i_frame_start) begin
            if (r_blink_cnt == BC_W'(BLINK_FRAMES-1)) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Underline cursor: bottom two glyph rows of the cursor cell while blink is on.
    assign w_cur_hit = r_blink_on && (w_cell == 12'(i_cursor_pos)) &&
                       (w_row >= FH_LOG'(FONT_H-2));
`else
    logic w_unused_cursor;
    assign w_unused_cursor = ^{i_cursor_pos, i_frame_start};
    assign w_cur_hit       = 1'b0;
`endif

    // Stage 1: cell address and in-cell position.
    logic [TA_W-1:0]   r1_text_addr;
    logic [FH_LOG-1:0] r1_row;
    logic [FW_LOG-1:0] r1_col;
    logic              r1_valid;
    logic              r1_cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_text_addr <= '0;
            r1_row       <= '0;
            r1_col       <= '0;
            r1_valid     <= 1'b0;
            r1_cur       <= 1'b0;
        end else begin
            r1_text_addr <= w_s1_valid ? TA_W'(w_cell) : '0;
            r1_row       <= w_row;
            r1_col       <= w_col;
            r1_valid     <= w_s1_valid;
            r1_cur       <= w_cur_hit;
        end
    end

    assign bus.text_addr = r1_text_addr;

    // Stage 2: text word arrives from RAM; glyph address formed from it.
    logic [FH_LOG-1:0] r2_row;
    logic [FW_LOG-1:0] r2_col;
    logic              r2_valid;
    logic              r2_cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_row   <= '0;
            r2_col   <= '0;
            r2_valid <= 1'b0;
            r2_cur   <= 1'b0;
        end else begin
            r2_row   <= r1_row;
            r2_col   <= r1_col;
            r2_valid <= r1_valid;
            r2_cur   <= r1_cur;
        end
    end

    always_comb begin
        bus.glyph_addr = '0;
        if (r2_valid) begin
            bus.glyph_addr = (GA_W'(bus.text_data[CHAR_W-1:0]) << FH_LOG) | GA_W'(r2_row);
        end
    end

    // Stage 3: capture attributes while the ROM fetches the glyph row.
    logic [23:0]       r3_fg;
    logic              r3_inv;
    logic [FW_LOG-1:0] r3_col;
    logic              r3_valid;
    logic              r3_cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3_fg    <= '0;
            r3_inv   <= 1'b0;
            r3_col   <= '0;
            r3_valid <= 1'b0;
            r3_cur   <= 1'b0;
        end else begin
            r3_fg    <= bus.text_data[31:8];
            r3_inv   <= bus.text_data[7];
            r3_col   <= r2_col;
            r3_valid <= r2_valid;
            r3_cur   <= r2_cur;
        end
    end

    // Stage 4: MSB of the glyph row is the leftmost pixel, so index with ~col.
    logic [FW_LOG-1:0] w_bit_idx;
    logic              w_lit;

    assign w_bit_idx = ~r3_col;
    assign w_lit     = (bus.glyph_data[w_bit_idx] | r3_cur) ^ r3_inv;

    logic        r_pixel;
    logic [23:0] r_colors;
    logic        r_out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pixel     <= 1'b0;
            r_colors    <= '0;
            r_out_valid <= 1'b0;
        end else if (r3_valid) begin
            r_pixel     <= w_lit;
            r_colors    <= w_lit ? r3_fg : i_bg_color;
            r_out_valid <= 1'b1;
        end else begin
            r_pixel     <= 1'b0;
            r_colors    <= '0;
            r_out_valid <= 1'b0;
        end
    end

    assign o_pixel     = r_pixel;
    assign o_colors    = r_colors;
    assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_text_painter_pipe.sv
// tb_text_painter_pipe: directed bench for text_painter_pipe with behavioural text RAM / glyph ROM.
// Cursor checks switch with TEXT_PAINTER_CURSOR_EN.
module tb_text_painter_pipe;

    localparam logic [23:0] BG = 24'h000040;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        act;
        logic [11:0] ta;
        logic [10:0] ga;
        logic        pix;
        logic [23:0] col;
        logic        v;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [9:0]  horz;
    logic [9:0]  vert;
    logic        active;
    logic        frame_start;
    logic [23:0] bg_color;
    logic [11:0] cursor_pos;
    logic        o_pixel;
    logic [23:0] o_colors;
    logic        o_out_valid;

    int n_checks;
    int n_errors;

    logic [31:0] text_mem [0:2399];
    logic [7:0]  rom      [0:2047];

    text_painter_pipe_if #(.FONT_W(8), .FONT_H(16), .COLS(80), .ROWS(30)) bus ();

    text_painter_pipe dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_horz_coord (horz),
        .i_vert_coord (vert),
        .i_active     (active),
        .i_frame_start(frame_start),
        .i_bg_color   (bg_color),
        .i_cursor_pos (cursor_pos),
        .o_pixel      (o_pixel),
        .o_colors     (o_colors),
        .o_out_valid  (o_out_valid),
        .bus          (bus)
    );

    // ---------------- clock / reset / memories ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.text_data  <= text_mem[bus.text_addr];
        bus.glyph_data <= rom[bus.glyph_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, exp finish before 500000");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic run_vec(input logic [9:0] x, input logic [9:0] y, input logic act,
                           output logic [11:0] ta, output logic [10:0] ga,
                           output logic pix, output logic [23:0] col, output logic v);
        @(negedge clk);
        horz = x; vert = y; active = act;
        @(negedge clk);
        active = 1'b0;
        ta = bus.text_addr;
        @(negedge clk);
        ga = bus.glyph_addr;
        repeat (2) @(negedge clk);
        pix = o_pixel; col = o_colors; v = o_out_valid;
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        horz = 10'd0; vert = 10'd0; active = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({o_pixel, o_colors, o_out_valid} !== 26'd0) begin
            n_errors++;
            $display("FAIL reset_out: got pix=%b col=%h v=%b exp 0/000000/0", o_pixel, o_colors, o_out_valid);
        end
        n_checks++;
        if ({bus.text_addr, bus.glyph_addr} !== 23'd0) begin
            n_errors++;
            $display("FAIL reset_addr: got ta=%0d ga=%0d exp 0/0", bus.text_addr, bus.glyph_addr);
        end
        active = 1'b0;
        rst_n  = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_glyph();
        vec_t vt[5];
        logic [11:0] ta; logic [10:0] ga; logic pix; logic [23:0] col; logic v;
        text_mem[0] = {24'hFF0000, 1'b0, 7'h41};
        rom[1040] = 8'h80;
        rom[1041] = 8'h01;
        rom[1043] = 8'h10;
        vt[0] = '{10'd0, 10'd0, 1'b1, 12'd0, 11'd1040, 1'b1, 24'hFF0000, 1'b1};
        vt[1] = '{10'd7, 10'd0, 1'b1, 12'd0, 11'd1040, 1'b0, BG,         1'b1};
        vt[2] = '{10'd7, 10'd1, 1'b1, 12'd0, 11'd1041, 1'b1, 24'hFF0000, 1'b1};
        vt[3] = '{10'd3, 10'd3, 1'b1, 12'd0, 11'd1043, 1'b1, 24'hFF0000, 1'b1};
        vt[4] = '{10'd2, 10'd3, 1'b1, 12'd0, 11'd1043, 1'b0, BG,         1'b1};
        foreach (vt[k]) begin
            run_vec(vt[k].x, vt[k].y, vt[k].act, ta, ga, pix, col, v);
            n_checks++;
            if (ta !== vt[k].ta) begin
                n_errors++;
                $display("FAIL glyph_ta[%0d]: got %0d exp %0d", k, ta, vt[k].ta);
            end
            n_checks++;
            if (ga !== vt[k].ga) begin
                n_errors++;
                $display("FAIL glyph_ga[%0d]: got %0d exp %0d", k, ga, vt[k].ga);
            end
            n_checks++;
            if ({pix, col, v} !== {vt[k].pix, vt[k].col, vt[k].v}) begin
                n_errors++;
                $display("FAIL glyph_out[%0d]: got %b/%h/%b exp %b/%h/%b", k, pix, col, v, vt[k].pix, vt[k].col, vt[k].v);
            end
        end
    endtask

    task automatic test_inverse();
        vec_t vt[5];
        logic [11:0] ta; logic [10:0] ga; logic pix; logic [23:0] col; logic v;
        text_mem[1] = {24'h00FF00, 1'b1, 7'h20};
        rom[517] = 8'h40;
        vt[0] = '{10'd8,  10'd0, 1'b1, 12'd1, 11'd512, 1'b1, 24'h00FF00, 1'b1};
        vt[1] = '{10'd15, 10'd0, 1'b1, 12'd1, 11'd512, 1'b1, 24'h00FF00, 1'b1};
        vt[2] = '{10'd11, 10'd2, 1'b1, 12'd1, 11'd514, 1'b1, 24'h00FF00, 1'b1};
        vt[3] = '{10'd9,  10'd5, 1'b1, 12'd1, 11'd517, 1'b0, BG,         1'b1};
        vt[4] = '{10'd10, 10'd5, 1'b1, 12'd1, 11'd517, 1'b1, 24'h00FF00, 1'b1};
        foreach (vt[k]) begin
            run_vec(vt[k].x, vt[k].y, vt[k].act, ta, ga, pix, col, v);
            n_checks++;
            if (ta !== vt[k].ta) begin
                n_errors++;
                $display("FAIL inv_ta[%0d]: got %0d exp %0d", k, ta, vt[k].ta);
            end
            n_checks++;
            if (ga !== vt[k].ga) begin
                n_errors++;
                $display("FAIL inv_ga[%0d]: got %0d exp %0d", k, ga, vt[k].ga);
            end
            n_checks++;
            if ({pix, col, v} !== {vt[k].pix, vt[k].col, vt[k].v}) begin
                n_errors++;
                $display("FAIL inv_out[%0d]: got %b/%h/%b exp %b/%h/%b", k, pix, col, v, vt[k].pix, vt[k].col, vt[k].v);
            end
        end
    endtask

    task automatic test_range();
        vec_t vt[6];
        logic [11:0] ta; logic [10:0] ga; logic pix; logic [23:0] col; logic v;
        text_mem[2399] = {24'h0000FF, 1'b0, 7'h01};
        rom[31] = 8'h01;
        vt[0] = '{10'd639,  10'd479,  1'b1, 12'd2399, 11'd31, 1'b1, 24'h0000FF, 1'b1};
        vt[1] = '{10'd632,  10'd479,  1'b1, 12'd2399, 11'd31, 1'b0, BG,         1'b1};
        vt[2] = '{10'd0,    10'd480,  1'b1, 12'd0,    11'd0,  1'b0, 24'h000000, 1'b0};
        vt[3] = '{10'd640,  10'd0,    1'b1, 12'd0,    11'd0,  1'b0, 24'h000000, 1'b0};
        vt[4] = '{10'd0,    10'd0,    1'b0, 12'd0,    11'd0,  1'b0, 24'h000000, 1'b0};
        vt[5] = '{10'd1023, 10'd1023, 1'b1, 12'd0,    11'd0,  1'b0, 24'h000000, 1'b0};
        foreach (vt[k]) begin
            run_vec(vt[k].x, vt[k].y, vt[k].act, ta, ga, pix, col, v);
            n_checks++;
            if (ta !== vt[k].ta) begin
                n_errors++;
                $display("FAIL range_ta[%0d]: got %0d exp %0d", k, ta, vt[k].ta);
            end
            if (vt[k].v) begin
                n_checks++;
                if (ga !== vt[k].ga) begin
                    n_errors++;
                    $display("FAIL range_ga[%0d]: got %0d exp %0d", k, ga, vt[k].ga);
                end
            end
            n_checks++;
            if ({pix, col, v} !== {vt[k].pix, vt[k].col, vt[k].v}) begin
                n_errors++;
                $display("FAIL range_out[%0d]: got %b/%h/%b exp %b/%h/%b", k, pix, col, v, vt[k].pix, vt[k].col, vt[k].v);
            end
        end
    endtask

    task automatic test_back_to_back();
        int j;
        int c;
        logic [11:0] exp_ta;
        logic        exp_pix;
        logic [23:0] exp_col;
        logic        exp_v;
        for (int k = 0; k < 80; k++) begin
            text_mem[k] = {16'h1000, 8'(k), 1'b0, 7'(k)};
            rom[k*16]   = 8'h80;
        end
        for (int i = 0; i <= 645; i++) begin
            @(negedge clk);
            if (i >= 1) begin
                j = i - 1;
                exp_ta = (j < 640) ? 12'(j >> 3) : 12'd0;
                n_checks++;
                if (bus.text_addr !== exp_ta) begin
                    n_errors++;
                    $display("FAIL sweep_ta x=%0d: got %0d exp %0d", j, bus.text_addr, exp_ta);
                end
            end
            if (i >= 4) begin
                j = i - 4;
                if (j < 640) begin
                    c       = j >> 3;
                    exp_pix = ((j % 8) == 0);
                    exp_col = exp_pix ? {16'h1000, 8'(c)} : BG;
                    exp_v   = 1'b1;
                end else begin
                    exp_pix = 1'b0;
                    exp_col = 24'h0;
                    exp_v   = 1'b0;
                end
                n_checks++;
                if ({o_pixel, o_colors, o_out_valid} !== {exp_pix, exp_col, exp_v}) begin
                    n_errors++;
                    $display("FAIL sweep_out x=%0d: got %b/%h/%b exp %b/%h/%b", j, o_pixel, o_colors, o_out_valid, exp_pix, exp_col, exp_v);
                end
            end
            if (i <= 640) begin
                horz = 10'(i); vert = 10'd0; active = 1'b1;
            end else begin
                active = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_line();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            horz = 10'(k); vert = 10'd0; active = 1'b1;
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_pixel, o_colors, o_out_valid, bus.text_addr, bus.glyph_addr} !== 49'd0) begin
            n_errors++;
            $display("FAIL async_reset: got pix=%b col=%h v=%b ta=%0d ga=%0d exp all 0", o_pixel, o_colors, o_out_valid, bus.text_addr, bus.glyph_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        horz = 10'd0; vert = 10'd0; active = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (k < 4) begin
                if ({o_pixel, o_colors, o_out_valid} !== 26'd0) begin
                    n_errors++;
                    $display("FAIL post_reset_gap[%0d]: got %b/%h/%b exp 0/000000/0", k, o_pixel, o_colors, o_out_valid);
                end
            end else begin
                if ({o_pixel, o_colors, o_out_valid} !== {1'b1, 24'h100000, 1'b1}) begin
                    n_errors++;
                    $display("FAIL post_reset_first: got %b/%h/%b exp 1/100000/1", o_pixel, o_colors, o_out_valid);
                end
            end
            horz = 10'(k);
        end
        @(negedge clk);
        active = 1'b0;
        repeat (5) @(negedge clk);
    endtask

`ifdef TEXT_PAINTER_CURSOR_EN
    task automatic test_cursor_blink();
        logic [11:0] ta; logic [10:0] ga; logic pix; logic [23:0] col; logic v;
        logic        exp_lit;
        text_mem[5] = {24'hABCDEF, 1'b0, 7'h30};
        cursor_pos  = 12'd5;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(10'd40, 10'd13, 1'b1, ta, ga, pix, col, v);
        n_checks++;
        if ({ta, ga, pix, col, v} !== {12'd5, 11'd781, 1'b0, BG, 1'b1}) begin
            n_errors++;
            $display("FAIL cursor_row13: got ta=%0d ga=%0d %b/%h/%b exp 5/781 0/%h/1", ta, ga, pix, col, v, BG);
        end
        for (int f = 0; f <= 60; f++) begin
            if (f == 0 || f == 29 || f == 30 || f == 59 || f == 60) begin
                exp_lit = (f < 30) || (f >= 60);
                run_vec(10'd40, 10'd14, 1'b1, ta, ga, pix, col, v);
                n_checks++;
                if ({pix, col, v} !== {exp_lit, exp_lit ? 24'hABCDEF : BG, 1'b1}) begin
                    n_errors++;
                    $display("FAIL cursor_y14 frame=%0d: got %b/%h/%b exp lit=%b", f, pix, col, v, exp_lit);
                end
                run_vec(10'd47, 10'd15, 1'b1, ta, ga, pix, col, v);
                n_checks++;
                if ({pix, col, v} !== {exp_lit, exp_lit ? 24'hABCDEF : BG, 1'b1}) begin
                    n_errors++;
                    $display("FAIL cursor_y15 frame=%0d: got %b/%h/%b exp lit=%b", f, pix, col, v, exp_lit);
                end
            end
            pulse_frame();
        end
        run_vec(10'd48, 10'd15, 1'b1, ta, ga, pix, col, v);
        n_checks++;
        if ({pix, col, v} !== {1'b0, BG, 1'b1}) begin
            n_errors++;
            $display("FAIL cursor_other_cell: got %b/%h/%b exp 0/%h/1", pix, col, v, BG);
        end
    endtask
`else
    task automatic test_cursor_ignored();
        logic [11:0] ta; logic [10:0] ga; logic pix; logic [23:0] col; logic v;
        text_mem[5] = {24'hABCDEF, 1'b0, 7'h30};
        cursor_pos  = 12'd5;
        pulse_frame();
        run_vec(10'd40, 10'd14, 1'b1, ta, ga, pix, col, v);
        n_checks++;
        if ({ta, ga, pix, col, v} !== {12'd5, 11'd782, 1'b0, BG, 1'b1}) begin
            n_errors++;
            $display("FAIL cursor_ignored_y14: got ta=%0d ga=%0d %b/%h/%b exp 5/782 0/%h/1", ta, ga, pix, col, v, BG);
        end
        run_vec(10'd47, 10'd15, 1'b1, ta, ga, pix, col, v);
        n_checks++;
        if ({pix, col, v} !== {1'b0, BG, 1'b1}) begin
            n_errors++;
            $display("FAIL cursor_ignored_y15: got %b/%h/%b exp 0/%h/1", pix, col, v, BG);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        horz        = 10'd0;
        vert        = 10'd0;
        active      = 1'b0;
        frame_start = 1'b0;
        bg_color    = BG;
        cursor_pos  = 12'hFFF;
        for (int k = 0; k < 2400; k++) text_mem[k] = 32'h0;
        for (int k = 0; k < 2048; k++) rom[k] = 8'h0;

        test_reset();
        test_glyph();
        test_inverse();
        test_range();
        test_back_to_back();
        test_reset_mid_line();
`ifdef TEXT_PAINTER_CURSOR_EN
        test_cursor_blink();
`else
        test_cursor_ignored();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
